mux4_tdm: RTL

//  4:1 time-division multiplexer; the sending end of the 1:4 demux link.
//  - Collects words from four producer channels, each through a 1-entry holding buffer.
//  - Arbitrates round-robin between the buffered channels.
//  - Emits one registered word per transfer on (i, s1, s0, e), with {s1,s0} = source channel.
//  - The far-end demux routes each word back to output a/b/c/d by {s1,s0}.

---
 rtl/mux4_tdm.sv | 100 ++++++++++
 1 files changed

// File: rtl/mux4_tdm.sv
// 4:1 time-division multiplexer: four 1-entry channel buffers, round-robin arbitration,
// registered (i, s1, s0, e) output with sink backpressure. Build option: MUX4_FIXED_PRIORITY_EN.
module mux4_tdm #(
  parameter int WIDTH = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [3:0]         in_valid,
  input  logic [4*WIDTH-1:0] in_data,
  output logic [3:0]         in_ready,
  output logic [WIDTH-1:0]   i,
  output logic               s1,
  output logic               s0,
  output logic               e,
  input  logic               rdy
);

  logic [3:0]       buf_v;
  logic [WIDTH-1:0] buf_d [4];
  logic [3:0]       capture;
  logic             load;
  logic             any_v;
  logic             do_gnt;
  logic [1:0]       gnt;
  logic [3:0]       gnt_mask;

  assign in_ready = ~buf_v & {4{~rst}};
  assign capture  = in_valid & in_ready;
  assign load     = ~e | rdy;
  assign any_v    = |buf_v;
  assign do_gnt   = load & any_v;
  assign gnt_mask = do_gnt ? (4'b0001 << gnt) : 4'b0000;

`ifdef MUX4_FIXED_PRIORITY_EN
  // Lowest-indexed pending channel wins; scanning downward lets the lowest index overwrite.
  always_comb begin
    gnt = 2'd0;
    for (int k = 3; k >= 0; k--) begin
      if (buf_v[k]) gnt = 2'(k);
    end
  end
`else
  typedef enum logic [1:0] {
    PTR_CH0 = 2'd0,
    PTR_CH1 = 2'd1,
    PTR_CH2 = 2'd2,
    PTR_CH3 = 2'd3
  } ptr_t;

  ptr_t ptr, ptr_nxt;

  // Scan ptr, ptr+1, ... (mod 4); the smallest offset is written last and wins.
  always_comb begin
    gnt = ptr;
    for (int k = 3; k >= 0; k--) begin
      if (buf_v[ptr + 2'(k)]) gnt = ptr + 2'(k);
    end
  end

  always_comb begin
    ptr_nxt = ptr;
    if (do_gnt) ptr_nxt = ptr_t'(gnt + 2'd1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ptr <= PTR_CH0;
    else     ptr <= ptr_nxt;
  end
`endif

  // Input stage: a channel refills only once its buffer has been granted away.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) buf_v <= 4'b0000;
    else     buf_v <= (buf_v | capture) & ~gnt_mask;
  end

  always_ff @(posedge clk) begin
    for (int c = 0; c < 4; c++) begin
      if (capture[c]) buf_d[c] <= in_data[c*WIDTH +: WIDTH];
    end
  end

  // Output stage: load a new word whenever the previous one is gone or being taken.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      e  <= 1'b0;
      i  <= '0;
      s1 <= 1'b0;
      s0 <= 1'b0;
    end else if (load) begin
      e <= any_v;
      if (any_v) begin
        i  <= buf_d[gnt];
        s1 <= gnt[1];
        s0 <= gnt[0];
      end
    end
  end

endmodule
